// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate extender: mode encoding and occupancy width.
package imm_ext_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned OCC_W  = 2;

    typedef enum logic [MODE_W-1:0] {
        IMM_SIGN = 2'b00,
        IMM_ZERO = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_SHL2 = 2'b11
    } imm_mode_t;

    // Entries held = main valid + skid valid.
    function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate widener: sign, zero, upper-load and branch-offset forms.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  imm_mode_t        mode,
    output logic [OUT_W-1:0] ext_c
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;

    assign sext = {{EXT_W{imm[IN_W-1]}}, imm};
    assign zext = {{EXT_W{1'b0}}, imm};

    // LUI drops any immediate bits shifted past OUT_W; SHL2 truncates likewise.
    always_comb begin
        ext_c = sext;
        case (mode)
            IMM_SIGN: ext_c = sext;
            IMM_ZERO: ext_c = zext;
            IMM_LUI:  ext_c = zext << EXT_W;
            IMM_SHL2: ext_c = sext << 2;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and a one-deep skid register.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [OCC_W-1:0]  occupancy
);

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] ext_c;

    logic [OUT_W-1:0] main_q,       main_n;
    logic [OUT_W-1:0] skid_q,       skid_n;
    logic             out_valid_q,  out_valid_n;
    logic             skid_valid_q, skid_valid_n;
    logic             in_ready_q,   in_ready_n;
    logic [OCC_W-1:0] occ_q,        occ_n;

    logic accept;
    logic transfer;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm   (in_imm),
        .mode  (imm_mode_t'(in_mode)),
        .ext_c (ext_c)
    );

    assign accept   = in_valid & in_ready_q;
    assign transfer = out_valid_q & out_ready;

    // Next-state: flush, skid drain, direct load, skid capture, drain to empty.
    always_comb begin
        main_n       = main_q;
        skid_n       = skid_q;
        out_valid_n  = out_valid_q;
        skid_valid_n = skid_valid_q;

        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (skid_valid_q && transfer) begin
            main_n       = skid_q;
            skid_valid_n = 1'b0;
        end else if (accept && (!out_valid_q || transfer)) begin
            main_n      = ext_c;
            out_valid_n = 1'b1;
        end else if (accept && out_valid_q && !out_ready) begin
            skid_n       = ext_c;
            skid_valid_n = 1'b1;
        end else if (transfer) begin
            out_valid_n = 1'b0;
        end

        in_ready_n = !skid_valid_n;
        occ_n      = occ_count(out_valid_n, skid_valid_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            occ_q        <= '0;
        end else begin
            main_q       <= main_n;
            skid_q       <= skid_n;
            out_valid_q  <= out_valid_n;
            skid_valid_q <= skid_valid_n;
            in_ready_q   <= in_ready_n;
            occ_q        <= occ_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomized checks of imm_extend_pipe against a two-entry FIFO reference.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    logic [31:0] last_head = '0;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Extension by arithmetic on signed/unsigned integer values, wrapped to 32 bits.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint u;
        longint s;
        u = longint'(imm);
        s = imm[15] ? u - 65536 : u;
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(u);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        chk("out_data",  out_data, (q.size() > 0) ? q[0] : last_head);
    endtask

    // One clock: check state, drive inputs at negedge, advance model at posedge.
    task automatic cycle(input logic iv, input logic [15:0] imm, input logic [1:0] mode,
                         input logic ordy, input logic fl);
        logic acc;
        logic xfer;
        check_model();
        in_valid  = iv;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = ordy;
        flush     = fl;
        acc  = iv && (q.size() < 2);
        xfer = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(ref_ext(imm, mode));
        end
        if (q.size() > 0) last_head = q[0];
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic sign extension, one-cycle latency.
        cycle(1'b1, 16'h47EA, 2'd0, 1'b1, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  out_data, 32'h0000_47EA);

        // Same immediate in three modes back to back.
        cycle(1'b1, 16'h8001, 2'd0, 1'b1, 1'b0);
        chk("t2_sign", out_data, 32'hFFFF_8001);
        cycle(1'b1, 16'h8001, 2'd1, 1'b1, 1'b0);
        chk("t2_zero", out_data, 32'h0000_8001);
        cycle(1'b1, 16'h8001, 2'd2, 1'b1, 1'b0);
        chk("t2_lui",  out_data, 32'h8001_0000);

        // Branch-offset form.
        cycle(1'b1, 16'hFFFF, 2'd3, 1'b1, 1'b0);
        chk("t3_shl2_neg", out_data, 32'hFFFF_FFFC);
        cycle(1'b1, 16'h0004, 2'd3, 1'b1, 1'b0);
        chk("t3_shl2_pos", out_data, 32'h0000_0010);
        cycle(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

        // Stall: A and B held, C refused until space frees, FIFO order kept.
        cycle(1'b1, 16'h000A, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 16'h000B, 2'd1, 1'b0, 1'b0);
        cycle(1'b1, 16'h000C, 2'd1, 1'b0, 1'b0);
        chk("t4_full_occ",   32'(occupancy), 32'd2);
        chk("t4_full_ready", 32'(in_ready),  32'd0);
        chk("t4_hold_a",     out_data, 32'h0000_000A);
        cycle(1'b1, 16'h000C, 2'd1, 1'b1, 1'b0);
        chk("t4_then_b", out_data, 32'h0000_000B);
        chk("t4_occ_1",  32'(occupancy), 32'd1);
        cycle(1'b1, 16'h000C, 2'd1, 1'b1, 1'b0);
        chk("t4_then_c", out_data, 32'h0000_000C);
        cycle(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

        // Flush while full drops both entries and the offered input.
        cycle(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 2'd0, 1'b0, 1'b0);
        chk("t5_full", 32'(occupancy), 32'd2);
        cycle(1'b1, 16'h3333, 2'd0, 1'b0, 1'b1);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_occ",   32'(occupancy), 32'd0);
        chk("t5_hold",  out_data, 32'h0000_1111);
        cycle(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);
        chk("t5_dropped", 32'(out_valid), 32'd0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 16'($urandom),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 16'hABCD, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 2'd2, 1'b0, 1'b0);
        check_model();
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data",  out_data,       32'd0);
        chk("t6_occ",   32'(occupancy), 32'd0);
        q.delete();
        last_head = '0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 100; i++) begin
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 16'($urandom),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0, 1'b0);
        end
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
